// File: rtl/badge_uart_pkg.sv
// Shared constants, command codes and sequencer state encoding for the badge UART
// command path.
package badge_uart_pkg;

    localparam int FRAME_BYTES = 18;
    localparam int DBITS       = 8;
    localparam int FRAME_W     = FRAME_BYTES * DBITS;
    localparam int BLOCK_W     = 128;

    localparam logic [7:0] CMD_SEND  = 8'd64;
    localparam logic [7:0] CMD_CAT   = 8'd65;
    localparam logic [7:0] CMD_KEY   = 8'd66;
    localparam logic [7:0] CMD_PT    = 8'd67;
    localparam logic [7:0] CAT_RESET = 8'h60;
    localparam logic [7:0] FILL_CHAR = 8'h3f;

    // Selectors carried in byte1 of a send request
    localparam logic [7:0] SEL_FLAG   = 8'h41;
    localparam logic [7:0] SEL_CIPHER = 8'h42;

    localparam logic [FRAME_W-1:0] DEFAULT_FLAG = "{uart_badge_flags}";

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DECODE   = 3'd1,
        ST_AES_WAIT = 3'd2,
        ST_TX_WAIT  = 3'd3,
        ST_TX_HOLD  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/uart_frame_check.sv
// Combinational framing check and field split of one UART frame: the frame is
// well formed when its last byte repeats the command byte.
module uart_frame_check
    import badge_uart_pkg::*;
(
    input  logic [FRAME_W-1:0] frame,
    output logic               frame_ok,
    output logic [7:0]         cmd,
    output logic [7:0]         arg,
    output logic [BLOCK_W-1:0] payload
);

    assign cmd      = frame[DBITS-1:0];
    assign arg      = frame[2*DBITS-1:DBITS];
    assign payload  = frame[DBITS +: BLOCK_W];
    assign frame_ok = (frame[FRAME_W-1 -: DBITS] == cmd);

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Command sequencer between the UART core and the AES engine: decodes frames,
// drives the AES start/valid handshake and owns the single TX frame buffer.
module uart_cmd_sequencer
    import badge_uart_pkg::*;
#(
    parameter int                 AES_TIMEOUT = 1024,
    parameter logic [FRAME_W-1:0] FLAG        = DEFAULT_FLAG
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FRAME_W-1:0] rx_frame,
    input  logic               rx_frame_valid,
    input  logic               tx_busy,
    output logic               tx_trigger,
    output logic [FRAME_W-1:0] tx_frame,
    output logic [BLOCK_W-1:0] aes_key,
    output logic [BLOCK_W-1:0] aes_text,
    output logic               aes_start,
    input  logic               aes_valid,
    input  logic [BLOCK_W-1:0] aes_result,
    output logic [7:0]         cat_status,
    output logic               busy,
    output logic               err
);

    localparam int               CNT_W       = $clog2(AES_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(AES_TIMEOUT);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(3);

    seq_state_e         state_q, state_d;
    logic [7:0]         cmd_q, cmd_d, arg_q, arg_d, cat_q, cat_d;
    logic [BLOCK_W-1:0] payload_q, payload_d, key_q, key_d, text_q, text_d, cipher_q, cipher_d;
    logic [FRAME_W-1:0] tx_frame_q, tx_frame_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               seen_busy_q, seen_busy_d;
    logic               aes_start_q, aes_start_d;

    logic               frame_ok;
    logic [7:0]         rx_cmd, rx_arg, cat_off;
    logic [BLOCK_W-1:0] rx_payload;
    logic               bad_cmd, aes_timeout;

    uart_frame_check u_frame_check (
        .frame    (rx_frame),
        .frame_ok (frame_ok),
        .cmd      (rx_cmd),
        .arg      (rx_arg),
        .payload  (rx_payload)
    );

    assign cat_off = arg_q - CMD_CAT;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            arg_q       <= '0;
            payload_q   <= '0;
            cat_q       <= 8'hFF;
            key_q       <= '0;
            text_q      <= '0;
            cipher_q    <= '0;
            tx_frame_q  <= FLAG;
            cnt_q       <= '0;
            seen_busy_q <= 1'b0;
            aes_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            arg_q       <= arg_d;
            payload_q   <= payload_d;
            cat_q       <= cat_d;
            key_q       <= key_d;
            text_q      <= text_d;
            cipher_q    <= cipher_d;
            tx_frame_q  <= tx_frame_d;
            cnt_q       <= cnt_d;
            seen_busy_q <= seen_busy_d;
            aes_start_q <= aes_start_d;
        end
    end

    always_comb begin : next_state
        state_d     = state_q;
        cmd_d       = cmd_q;
        arg_d       = arg_q;
        payload_d   = payload_q;
        cat_d       = cat_q;
        key_d       = key_q;
        text_d      = text_q;
        cipher_d    = cipher_q;
        tx_frame_d  = tx_frame_q;
        cnt_d       = cnt_q;
        seen_busy_d = seen_busy_q;
        aes_start_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_frame_valid && frame_ok) begin
                    state_d   = ST_DECODE;
                    cmd_d     = rx_cmd;
                    arg_d     = rx_arg;
                    payload_d = rx_payload;
                end
            end
            ST_DECODE: begin
                state_d = ST_IDLE;
                case (cmd_q)
                    CMD_CAT: begin
                        if (arg_q == CAT_RESET)   cat_d = 8'hFF;
                        else if (cat_off < 8'd8)  cat_d[cat_off[2:0]] = 1'b0;
                    end
                    CMD_KEY: key_d = payload_q;
                    CMD_PT: begin
                        text_d      = payload_q;
                        aes_start_d = 1'b1;
                        state_d     = ST_AES_WAIT;
                    end
                    CMD_SEND: begin
                        state_d = ST_TX_WAIT;
                        if (arg_q == SEL_FLAG)        tx_frame_d = FLAG;
                        else if (arg_q == SEL_CIPHER) tx_frame_d = {cipher_q, 16'h0000};
                        else                          tx_frame_d = {FRAME_BYTES{FILL_CHAR}};
                    end
                    default: ;
                endcase
            end
            ST_AES_WAIT: begin
                // A result arriving on the timeout cycle is still accepted
                if (aes_valid) begin
                    cipher_d = aes_result;
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_TIMEOUT) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_TX_WAIT: begin
                if (!tx_busy) state_d = ST_TX_HOLD;
            end
            ST_TX_HOLD: begin
                // Release after busy rises and falls, or after four quiet cycles
                if (tx_busy) begin
                    seen_busy_d = 1'b1;
                end else if (seen_busy_q || cnt_q == HOLD_LAST) begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    seen_busy_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin : outputs
        busy        = (state_q != ST_IDLE);
        tx_trigger  = (state_q == ST_TX_WAIT) && !tx_busy;
        bad_cmd     = (state_q == ST_DECODE) &&
                      !(cmd_q inside {CMD_SEND, CMD_CAT, CMD_KEY, CMD_PT});
        aes_timeout = (state_q == ST_AES_WAIT) && !aes_valid && (cnt_q == CNT_TIMEOUT);
        err         = (rx_frame_valid && ((state_q != ST_IDLE) || !frame_ok)) ||
                      bad_cmd || aes_timeout;
    end

    assign tx_frame   = tx_frame_q;
    assign aes_key    = key_q;
    assign aes_text   = text_q;
    assign aes_start  = aes_start_q;
    assign cat_status = cat_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed bench for uart_cmd_sequencer with a frame-level reference model and
// a per-cycle compare of the architectural registers whenever the sequencer is idle.
`timescale 1ns/1ps
module tb_uart_cmd_sequencer;

    localparam int FB  = 18;
    localparam int FW  = FB * 8;
    localparam int TMO = 1024;
    localparam logic [FW-1:0]  TB_FLAG = "{uart_badge_flags}";
    localparam logic [FW-1:0]  FILL    = {FB{8'h3f}};
    localparam logic [127:0]   KEY     = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0]   PT      = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0]   DEAD    = 128'hDEADBEEF0123456789ABCDEFCAFEF00D;
    localparam logic [127:0]   CIPH2   = 128'h5555AAAA5555AAAA1234567890ABCDEF;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [FW-1:0]  rx_frame = '0;
    logic           rx_frame_valid = 1'b0;
    logic           tx_busy = 1'b0;
    logic           tx_trigger;
    logic [FW-1:0]  tx_frame;
    logic [127:0]   aes_key, aes_text;
    logic           aes_start;
    logic           aes_valid = 1'b0;
    logic [127:0]   aes_result = '0;
    logic [7:0]     cat_status;
    logic           busy, err;

    uart_cmd_sequencer #(.AES_TIMEOUT(TMO), .FLAG(TB_FLAG)) dut (
        .clk            (clk),
        .reset          (reset),
        .rx_frame       (rx_frame),
        .rx_frame_valid (rx_frame_valid),
        .tx_busy        (tx_busy),
        .tx_trigger     (tx_trigger),
        .tx_frame       (tx_frame),
        .aes_key        (aes_key),
        .aes_text       (aes_text),
        .aes_start      (aes_start),
        .aes_valid      (aes_valid),
        .aes_result     (aes_result),
        .cat_status     (cat_status),
        .busy           (busy),
        .err            (err)
    );

    always #5 clk = ~clk;

    int n_total = 0, n_pass = 0;
    int cyc = 0, n_trig = 0, n_start = 0, n_err = 0;
    int trig_cyc = 0, start_cyc = 0, err_cyc = 0;

    // Reference model state
    logic [7:0]    m_cat = 8'hFF;
    logic [127:0]  m_key = '0, m_text = '0, m_cipher = '0;
    logic [FW-1:0] m_tx = TB_FLAG;
    int            m_trig = 0, m_start = 0, m_err = 0;

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [FW-1:0] frame3(input logic [7:0] b0, input logic [7:0] b1,
                                              input logic [7:0] b17);
        return {b17, {15{8'h2e}}, b1, b0};
    endfunction

    function automatic logic [FW-1:0] framep(input logic [7:0] c, input logic [127:0] pl);
        return {c, pl, c};
    endfunction

    task automatic model_reset();
        m_cat = 8'hFF; m_key = '0; m_text = '0; m_cipher = '0; m_tx = TB_FLAG;
    endtask

    // Frame-level effect of one received frame on the architectural state
    task automatic model_apply(input logic [FW-1:0] f, input bit dropped);
        logic [7:0] b0, b1, off;
        b0 = f[7:0];
        b1 = f[15:8];
        off = b1 - 8'h41;
        if (dropped || f[FW-1 -: 8] != b0) begin
            m_err++;
            return;
        end
        case (b0)
            "A": begin
                if (b1 == 8'h60) m_cat = 8'hFF;
                else if (b1 >= "A" && b1 <= "H") m_cat[off[2:0]] = 1'b0;
            end
            "B": m_key = f[135:8];
            "C": begin m_text = f[135:8]; m_start++; end
            "@": begin
                m_trig++;
                m_tx = (b1 == "A") ? TB_FLAG : (b1 == "B") ? {m_cipher, 16'h0000} : FILL;
            end
            default: m_err++;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a frame for one cycle; returns the err level seen during that cycle
    task automatic send(input logic [FW-1:0] f, input bit dropped, output logic err_now);
        rx_frame = f;
        rx_frame_valid = 1'b1;
        model_apply(f, dropped);
        #1 err_now = err;
        @(posedge clk);
        #1 rx_frame_valid = 1'b0;
        #1;
    endtask

    task automatic tx_check(input logic [7:0] sel, input logic [FW-1:0] expf, input string name);
        logic e;
        tx_busy = 1'b0;
        send(frame3("@", sel, "@"), 1'b0, e);
        tick();
        chk1({name, "_trig"}, tx_trigger, 1'b1);
        chk({name, "_frame"}, tx_frame, expf);
        tick(); tick(); tick();
        chk1({name, "_hold"}, busy, 1'b1);
        tick(); tick();
        chk1({name, "_idle"}, busy, 1'b0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Strobe monitor plus per-cycle compare against the model while idle
    initial forever begin
        @(negedge clk);
        if (tx_trigger) begin n_trig++; trig_cyc = cyc; end
        if (aes_start)  begin n_start++; start_cyc = cyc; end
        if (err)        begin n_err++; err_cyc = cyc; end
        if (!busy && !rx_frame_valid) begin
            chk("cmp_cat", FW'(cat_status), FW'(m_cat));
            chk("cmp_key", FW'(aes_key), FW'(m_key));
            chk("cmp_text", FW'(aes_text), FW'(m_text));
            chk("cmp_txframe", tx_frame, m_tx);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic e;
        int errs, k;

        // Reset values
        reset = 1'b1;
        repeat (3) tick();
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_trig", tx_trigger, 1'b0);
        chk1("rst_start", aes_start, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk("rst_cat", FW'(cat_status), FW'(8'hFF));
        chk("rst_key", FW'(aes_key), '0);
        chk("rst_text", FW'(aes_text), '0);
        chk("rst_txframe", tx_frame, TB_FLAG);
        chk("rst_flag_hi", FW'(tx_frame[143:136]), FW'(8'h7b));
        chk("rst_flag_lo", FW'(tx_frame[7:0]), FW'(8'h7d));
        reset = 1'b0;
        tick(); tick();

        // Cat LEDs
        send(frame3("A", "C", "A"), 1'b0, e);
        chk1("t1_no_err", e, 1'b0);
        chk("t1_cat_n1", FW'(cat_status), FW'(8'hFF));
        chk1("t1_busy_n1", busy, 1'b1);
        tick();
        chk("t1_cat_n2", FW'(cat_status), FW'(8'hFB));
        chk1("t1_idle_n2", busy, 1'b0);
        send(frame3("A", "H", "A"), 1'b0, e);
        tick();
        chk("t1_cat_h", FW'(cat_status), FW'(8'h7B));
        send(frame3("A", "I", "A"), 1'b0, e);
        chk1("t1_i_no_err", err, 1'b0);
        tick();
        chk("t1_cat_i", FW'(cat_status), FW'(8'h7B));
        send(frame3("A", 8'h60, "A"), 1'b0, e);
        tick();
        chk("t1_cat_clr", FW'(cat_status), FW'(8'hFF));

        // Flag request and tx_busy handshake
        tx_busy = 1'b0;
        send(frame3("@", "A", "@"), 1'b0, e);
        chk1("t2_trig_n1", tx_trigger, 1'b0);
        tick();
        chk1("t2_trig_n2", tx_trigger, 1'b1);
        chk("t2_frame", tx_frame, TB_FLAG);
        tick();
        chk1("t2_trig_once", tx_trigger, 1'b0);
        chk1("t2_hold_busy", busy, 1'b1);
        tx_busy = 1'b1;
        repeat (10) tick();
        chk1("t2_still_busy", busy, 1'b1);
        chk("t2_frame_stable", tx_frame, TB_FLAG);
        tx_busy = 1'b0;
        tick();
        chk1("t2_idle", busy, 1'b0);
        chk_int("t2_trig_count", n_trig, m_trig);

        // Key, plaintext, AES handshake with result after 20 cycles
        send(framep("B", KEY), 1'b0, e);
        tick();
        chk("t3_key", FW'(aes_key), FW'(KEY));
        send(framep("C", PT), 1'b0, e);
        chk1("t3_start_n1", aes_start, 1'b0);
        tick();
        chk1("t3_start", aes_start, 1'b1);
        chk("t3_text", FW'(aes_text), FW'(PT));
        tick();
        chk1("t3_start_once", aes_start, 1'b0);
        chk1("t3_wait_busy", busy, 1'b1);
        repeat (19) tick();
        aes_valid = 1'b1;
        aes_result = DEAD;
        m_cipher = DEAD;
        tick();
        aes_valid = 1'b0;
        #1;
        chk1("t3_aes_done", busy, 1'b0);
        chk_int("t3_start_count", n_start, m_start);
        tx_check("B", {DEAD, 16'h0000}, "t3_cipher");

        // AES timeout, then result exactly on the timeout cycle
        send(framep("C", ~PT), 1'b0, e);
        tick();
        chk1("t4_start", aes_start, 1'b1);
        m_err++;
        errs = n_err;
        k = 0;
        while (n_err == errs && k < TMO + 20) begin tick(); k++; end
        chk_int("t4_err_seen", n_err, errs + 1);
        chk_int("t4_err_delay", err_cyc - start_cyc, TMO);
        chk1("t4_idle", busy, 1'b0);
        tx_check("B", {DEAD, 16'h0000}, "t4_cipher_kept");
        send(framep("C", PT ^ KEY), 1'b0, e);
        tick();
        repeat (TMO) tick();
        aes_valid = 1'b1;
        aes_result = CIPH2;
        m_cipher = CIPH2;
        #1;
        chk1("t4b_no_err", err, 1'b0);
        chk1("t4b_busy", busy, 1'b1);
        tick();
        aes_valid = 1'b0;
        #1;
        chk1("t4b_idle", busy, 1'b0);
        tx_check("B", {CIPH2, 16'h0000}, "t4b_cipher");

        // Bad end char, unknown command, frame dropped during TX_WAIT
        send(frame3("A", "C", "Z"), 1'b0, e);
        chk1("t5_bad_err", e, 1'b1);
        chk1("t5_bad_idle", busy, 1'b0);
        send(frame3("Z", "x", "Z"), 1'b0, e);
        chk1("t5_badcmd_err", err, 1'b1);
        tick();
        chk1("t5_badcmd_idle", busy, 1'b0);
        tx_busy = 1'b1;
        send(frame3("@", "Q", "@"), 1'b0, e);
        tick();
        chk1("t5_txwait_notrig", tx_trigger, 1'b0);
        send(frame3("A", "B", "A"), 1'b1, e);
        chk1("t5_drop_err", e, 1'b1);
        chk("t5_drop_cat", FW'(cat_status), FW'(8'hFF));
        tick();
        chk("t5_fill_frame", tx_frame, FILL);
        tx_busy = 1'b0;
        #1;
        chk1("t5_trig", tx_trigger, 1'b1);
        tick();
        k = 0;
        while (busy && k < 8) begin tick(); k++; end
        chk1("t5_idle", busy, 1'b0);
        chk_int("t5_err_count", n_err, m_err);

        // Reset while waiting on AES
        send(framep("C", KEY ^ DEAD), 1'b0, e);
        tick();
        repeat (5) tick();
        reset = 1'b1;
        model_reset();
        #1;
        chk1("t6a_busy", busy, 1'b0);
        chk1("t6a_start", aes_start, 1'b0);
        chk1("t6a_err", err, 1'b0);
        chk("t6a_text", FW'(aes_text), '0);
        chk("t6a_key", FW'(aes_key), '0);
        chk("t6a_txframe", tx_frame, TB_FLAG);
        tick(); tick();
        reset = 1'b0;
        repeat (8) tick();
        chk_int("t6a_err_count", n_err, m_err);
        chk_int("t6a_start_count", n_start, m_start);

        // Reset while waiting on the transmitter
        tx_busy = 1'b1;
        send(frame3("@", "A", "@"), 1'b0, e);
        tick();
        chk1("t6b_txwait", busy, 1'b1);
        reset = 1'b1;
        model_reset();
        m_trig--;  // the held-off trigger is cancelled by reset
        #1;
        tx_busy = 1'b0;
        #1;
        chk1("t6b_trig", tx_trigger, 1'b0);
        chk1("t6b_busy", busy, 1'b0);
        tick(); tick();
        reset = 1'b0;
        repeat (5) tick();
        chk_int("t6b_trig_count", n_trig, m_trig);
        tx_check("B", {128'h0, 16'h0000}, "t6_cipher_rst");
        chk_int("final_err_count", n_err, m_err);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
